// File: rtl/sao_rdo_select.sv
// SAO rate-distortion selector: keeps the minimum-cost SAO candidate per component and emits Y/Cb/Cr results.
// Optional debug outputs (sao_cost, cand_cnt) are enabled with `define SAO_RDO_COST_DBG_EN.
module sao_rdo_select #(
  parameter int SHIFT         = 24,
  parameter int NUM_LUMA_DC   = 64 - SHIFT,
  parameter int NUM_CHROMA_DC = 60 - SHIFT,
  parameter int CNT_W         = 6,
  parameter int COST_W        = 24,
  parameter int OFF_W         = 4
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 rst_n,
  input  logic                 en_o,
  input  logic                 isWorking_deci,
  input  logic [CNT_W-1:0]     cnt_dc_fsm,
  input  logic [1:0]           cIdx_fsm,
  input  logic                 cand_valid,
  input  logic [1:0]           cand_type,
  input  logic [4:0]           cand_class,
  input  logic [4*OFF_W-1:0]   cand_off,
  input  logic [COST_W-1:0]    cand_cost,
  output logic                 sao_valid,
  output logic [1:0]           sao_cIdx,
  output logic [1:0]           sao_type,
  output logic [4:0]           sao_class,
  output logic [4*OFF_W-1:0]   sao_off,
  output logic                 ctb_done,
  output logic                 proto_err
`ifdef SAO_RDO_COST_DBG_EN
  ,
  output logic [COST_W-1:0]    sao_cost,
  output logic [CNT_W:0]       cand_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(NUM_LUMA_DC - 1);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM_CHROMA_DC - 1);
  localparam logic [1:0]       T_OFF  = 2'd0;
  localparam logic [1:0]       T_ILL  = 2'd3;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t               state;
  state_t               state_nxt;

  logic [1:0]           exp_cidx;
  logic [CNT_W-1:0]     exp_cnt;
  logic [COST_W-1:0]    best_cost;
  logic [1:0]           best_type;
  logic [4:0]           best_class;
  logic [4*OFF_W-1:0]   best_off;

  logic                 accept;
  logic                 comp_start;
  logic                 is_last;
  logic                 bad_type;
  logic                 seq_bad;
  logic                 take;
  logic                 err;
  logic                 replace;
  logic [COST_W-1:0]    base_cost;
  logic [1:0]           base_type;
  logic [4:0]           base_class;
  logic [4*OFF_W-1:0]   base_off;
  logic [COST_W-1:0]    new_cost;
  logic [1:0]           new_type;
  logic [4:0]           new_class;
  logic [4*OFF_W-1:0]   new_off;

`ifdef SAO_RDO_COST_DBG_EN
  logic [CNT_W:0]       acc_num;
  logic [CNT_W:0]       new_num;
`endif

  assign accept     = en_o & isWorking_deci & cand_valid;
  assign comp_start = (cnt_dc_fsm == {CNT_W{1'b0}});
  assign is_last    = (cnt_dc_fsm == ((cIdx_fsm == 2'd0) ? LAST_Y : LAST_C));
  assign bad_type   = (cand_type == T_ILL);
  assign seq_bad    = (cIdx_fsm != exp_cidx) || (cnt_dc_fsm != exp_cnt);

  // Sample classification: legal sample to fold in, or protocol violation
  always_comb begin
    take = 1'b0;
    err  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && comp_start) begin
          if (bad_type || (cIdx_fsm != 2'd0)) begin
            err = 1'b1;
          end else begin
            take = 1'b1;
          end
        end else begin
          take = 1'b0;
        end
      end
      ACC: begin
        if (accept) begin
          if (bad_type || seq_bad) begin
            err = 1'b1;
          end else begin
            take = 1'b1;
          end
        end else begin
          take = 1'b0;
        end
      end
      default: begin
        take = 1'b0;
        err  = 1'b0;
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take) begin
          state_nxt = ACC;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACC: begin
        if (err || (take && is_last && (cIdx_fsm == 2'd2))) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = ACC;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Candidate versus running best; a component start compares against SAO off at cost 0
  always_comb begin
    if (comp_start) begin
      base_cost  = {COST_W{1'b0}};
      base_type  = T_OFF;
      base_class = 5'd0;
      base_off   = {(4*OFF_W){1'b0}};
    end else begin
      base_cost  = best_cost;
      base_type  = best_type;
      base_class = best_class;
      base_off   = best_off;
    end
    replace = ($signed(cand_cost) < $signed(base_cost));
    if (replace) begin
      new_cost  = cand_cost;
      new_type  = cand_type;
      new_class = cand_class;
      new_off   = (cand_type == T_OFF) ? {(4*OFF_W){1'b0}} : cand_off;
    end else begin
      new_cost  = base_cost;
      new_type  = base_type;
      new_class = base_class;
      new_off   = base_off;
    end
  end

`ifdef SAO_RDO_COST_DBG_EN
  assign new_num = comp_start ? {{CNT_W{1'b0}}, 1'b1} : (acc_num + {{CNT_W{1'b0}}, 1'b1});
`endif

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else if (!rst_n) begin
      state <= IDLE;
    end else if (en_o) begin
      state <= state_nxt;
    end
  end

  // Accumulator, sequence tracking and registered result outputs
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      exp_cidx   <= 2'd0;
      exp_cnt    <= {CNT_W{1'b0}};
      best_cost  <= {COST_W{1'b0}};
      best_type  <= 2'd0;
      best_class <= 5'd0;
      best_off   <= {(4*OFF_W){1'b0}};
      sao_valid  <= 1'b0;
      sao_cIdx   <= 2'd0;
      sao_type   <= 2'd0;
      sao_class  <= 5'd0;
      sao_off    <= {(4*OFF_W){1'b0}};
      ctb_done   <= 1'b0;
      proto_err  <= 1'b0;
`ifdef SAO_RDO_COST_DBG_EN
      acc_num    <= {(CNT_W+1){1'b0}};
      sao_cost   <= {COST_W{1'b0}};
      cand_cnt   <= {(CNT_W+1){1'b0}};
`endif
    end else if (!rst_n) begin
      exp_cidx   <= 2'd0;
      exp_cnt    <= {CNT_W{1'b0}};
      best_cost  <= {COST_W{1'b0}};
      best_type  <= 2'd0;
      best_class <= 5'd0;
      best_off   <= {(4*OFF_W){1'b0}};
      sao_valid  <= 1'b0;
      sao_cIdx   <= 2'd0;
      sao_type   <= 2'd0;
      sao_class  <= 5'd0;
      sao_off    <= {(4*OFF_W){1'b0}};
      ctb_done   <= 1'b0;
      proto_err  <= 1'b0;
`ifdef SAO_RDO_COST_DBG_EN
      acc_num    <= {(CNT_W+1){1'b0}};
      sao_cost   <= {COST_W{1'b0}};
      cand_cnt   <= {(CNT_W+1){1'b0}};
`endif
    end else if (en_o) begin
      sao_valid <= 1'b0;
      ctb_done  <= 1'b0;
      if (err) begin
        proto_err <= 1'b1;
      end
      if (take) begin
        best_cost  <= new_cost;
        best_type  <= new_type;
        best_class <= new_class;
        best_off   <= new_off;
`ifdef SAO_RDO_COST_DBG_EN
        acc_num    <= new_num;
`endif
        if (is_last) begin
          exp_cnt   <= {CNT_W{1'b0}};
          exp_cidx  <= (cIdx_fsm == 2'd2) ? 2'd0 : (cIdx_fsm + 2'd1);
          sao_valid <= 1'b1;
          sao_cIdx  <= cIdx_fsm;
          sao_type  <= new_type;
          sao_class <= new_class;
          sao_off   <= new_off;
          ctb_done  <= (cIdx_fsm == 2'd2);
`ifdef SAO_RDO_COST_DBG_EN
          sao_cost  <= new_cost;
          cand_cnt  <= new_num;
`endif
        end else begin
          exp_cnt  <= cnt_dc_fsm + {{(CNT_W-1){1'b0}}, 1'b1};
          exp_cidx <= cIdx_fsm;
        end
      end
    end
  end

endmodule

// File: tb/tb_sao_rdo_select.sv
// Directed bench for sao_rdo_select: table of per-component vectors plus hold, reset and protocol-error sequences.
module tb_sao_rdo_select;

  logic        clk = 1'b0;
  logic        arst_n, rst_n, en_o, isWorking_deci, cand_valid;
  logic [5:0]  cnt_dc_fsm;
  logic [1:0]  cIdx_fsm, cand_type;
  logic [4:0]  cand_class;
  logic [15:0] cand_off;
  logic [23:0] cand_cost;
  logic        sao_valid, ctb_done, proto_err;
  logic [1:0]  sao_cIdx, sao_type;
  logic [4:0]  sao_class;
  logic [15:0] sao_off;
`ifdef SAO_RDO_COST_DBG_EN
  logic [23:0] sao_cost;
  logic [6:0]  cand_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sao_rdo_select dut (
    .clk(clk), .arst_n(arst_n), .rst_n(rst_n), .en_o(en_o),
    .isWorking_deci(isWorking_deci), .cnt_dc_fsm(cnt_dc_fsm), .cIdx_fsm(cIdx_fsm),
    .cand_valid(cand_valid), .cand_type(cand_type), .cand_class(cand_class),
    .cand_off(cand_off), .cand_cost(cand_cost),
    .sao_valid(sao_valid), .sao_cIdx(sao_cIdx), .sao_type(sao_type),
    .sao_class(sao_class), .sao_off(sao_off), .ctb_done(ctb_done), .proto_err(proto_err)
`ifdef SAO_RDO_COST_DBG_EN
    , .sao_cost(sao_cost), .cand_cnt(cand_cnt)
`endif
  );

  typedef struct {
    logic [1:0]  cidx;
    int          def;
    int          ia;
    logic [1:0]  ta;
    logic [4:0]  ca;
    logic [15:0] oa;
    int          costa;
    int          ib;
    logic [1:0]  tb;
    logic [4:0]  cb;
    logic [15:0] ob;
    int          costb;
    logic [1:0]  e_type;
    logic [4:0]  e_class;
    logic [15:0] e_off;
    logic        e_done;
    int          e_cost;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] ci, input int cnt, input logic [1:0] ty,
                      input logic [4:0] cl, input logic [15:0] of, input int cost);
    isWorking_deci = 1'b1;
    cand_valid = 1'b1;
    cIdx_fsm = ci;
    cnt_dc_fsm = 6'(cnt);
    cand_type = ty;
    cand_class = cl;
    cand_off = of;
    cand_cost = 24'(cost);
    @(posedge clk); #1;
    cand_valid = 1'b0;
  endtask

  task automatic check_result(input vec_t v, input logic perr);
    int last;
    last = (v.cidx == 2'd0) ? 39 : 35;
    chk("valid", 32'(sao_valid), 32'd1);
    chk("cidx", 32'(sao_cIdx), 32'(v.cidx));
    chk("type", 32'(sao_type), 32'(v.e_type));
    chk("class", 32'(sao_class), 32'(v.e_class));
    chk("off", 32'(sao_off), 32'(v.e_off));
    chk("done", 32'(ctb_done), 32'(v.e_done));
    chk("perr", 32'(proto_err), 32'(perr));
`ifdef SAO_RDO_COST_DBG_EN
    chk("dbg_cost", 32'(sao_cost), 32'(24'(v.e_cost)));
    chk("dbg_cnt", 32'(cand_cnt), 32'(last + 1));
`endif
  endtask

  // Feeds one whole component; with hold=1 the last sample straddles an en_o-low window
  task automatic run_comp(input vec_t v, input logic perr, input logic hold);
    int last;
    int early;
    int held;
    last = (v.cidx == 2'd0) ? 39 : 35;
    early = 0;
    for (int c = 0; c <= last; c++) begin
      if (hold && c == last) break;
      if (c == v.ia) send(v.cidx, c, v.ta, v.ca, v.oa, v.costa);
      else if (c == v.ib) send(v.cidx, c, v.tb, v.cb, v.ob, v.costb);
      else send(v.cidx, c, 2'd2, 5'd1, 16'h1111, v.def);
      if (c < last && sao_valid !== 1'b0) early++;
    end
    chk("early_valid", 32'(early), 32'd0);
    if (hold) begin
      held = 0;
      isWorking_deci = 1'b1; cand_valid = 1'b1; cIdx_fsm = v.cidx; cnt_dc_fsm = 6'(last);
      cand_type = 2'd2; cand_class = 5'd1; cand_off = 16'h1111; cand_cost = 24'(v.def);
      en_o = 1'b0;
      repeat (2) begin
        @(posedge clk); #1;
        if (sao_valid !== 1'b0) held++;
      end
      chk("hold_pre_valid", 32'(held), 32'd0);
      en_o = 1'b1;
      @(posedge clk); #1;
      cand_valid = 1'b0;
      en_o = 1'b0;
      check_result(v, perr);
      repeat (3) begin
        @(posedge clk); #1;
        chk("hold_valid", 32'(sao_valid), 32'd1);
        chk("hold_class", 32'(sao_class), 32'(v.e_class));
      end
      en_o = 1'b1;
      @(posedge clk); #1;
      chk("hold_release", 32'(sao_valid), 32'd0);
    end else begin
      check_result(v, perr);
    end
  endtask

  task automatic feed_ignored(input int from, input int to, input string name);
    int pulses;
    pulses = 0;
    for (int c = from; c <= to; c++) begin
      send(2'd0, c, 2'd2, 5'd1, 16'h1111, -9);
      if (sao_valid !== 1'b0) pulses++;
    end
    chk(name, 32'(pulses), 32'd0);
  endtask

  task automatic pulse_srst();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{2'd0, 5, -1, 2'd0, 5'd0, 16'h0000, 0, -1, 2'd0, 5'd0, 16'h0000, 0,
                2'd0, 5'd0, 16'h0000, 1'b0, 0};
    vecs[1] = '{2'd1, 0, 35, 2'd1, 5'd9, 16'h21F3, -1, -1, 2'd0, 5'd0, 16'h0000, 0,
                2'd1, 5'd9, 16'h21F3, 1'b0, -1};
    vecs[2] = '{2'd2, 0, 0, 2'd2, 5'd3, 16'h4321, -50, 10, 2'd1, 5'd5, 16'h5555, -49,
                2'd2, 5'd3, 16'h4321, 1'b1, -50};
    vecs[3] = '{2'd0, 0, 7, 2'd2, 5'd2, 16'hA5C3, -300, 20, 2'd1, 5'd13, 16'h3C5A, -300,
                2'd2, 5'd2, 16'hA5C3, 1'b0, -300};
    vecs[4] = '{2'd1, 100, 5, 2'd0, 5'd0, 16'h7777, -10, -1, 2'd0, 5'd0, 16'h0000, 0,
                2'd0, 5'd0, 16'h0000, 1'b0, -10};
    vecs[5] = '{2'd2, 3, 2, 2'd1, 5'd7, 16'h0123, -1, 35, 2'd2, 5'd0, 16'h8899, -8388608,
                2'd2, 5'd0, 16'h8899, 1'b1, -8388608};
    vecs[6] = '{2'd0, 0, 0, 2'd1, 5'd2, 16'h0F0F, -1, 39, 2'd1, 5'd31, 16'hFFFF, -2,
                2'd1, 5'd31, 16'hFFFF, 1'b0, -2};
    vecs[7] = '{2'd1, 0, 0, 2'd1, 5'd3, 16'h1234, 8388607, -1, 2'd0, 5'd0, 16'h0000, 0,
                2'd0, 5'd0, 16'h0000, 1'b0, 0};
    vecs[8] = '{2'd2, 1, 1, 2'd2, 5'd1, 16'h0101, -5, 2, 2'd2, 5'd2, 16'h0202, -6,
                2'd2, 5'd2, 16'h0202, 1'b1, -6};

    arst_n = 1'b0; rst_n = 1'b1; en_o = 1'b1; isWorking_deci = 1'b0; cand_valid = 1'b0;
    cnt_dc_fsm = 6'd0; cIdx_fsm = 2'd0; cand_type = 2'd0; cand_class = 5'd0;
    cand_off = 16'h0000; cand_cost = 24'd0;
    #12;
    chk("reset_outs", {7'd0, sao_valid, sao_cIdx, sao_type, sao_class, sao_off, ctb_done, proto_err}, 32'd0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Y with en_o held low across the last sample and the result cycle
    run_comp(vecs[3], 1'b0, 1'b1);

    // Async reset in the middle of Cb discards everything
    for (int c = 0; c <= 10; c++) send(2'd1, c, 2'd2, 5'd1, 16'h1111, -7);
    #2 arst_n = 1'b0;
    #2;
    chk("arst_outs", {7'd0, sao_valid, sao_cIdx, sao_type, sao_class, sao_off, ctb_done, proto_err}, 32'd0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Three back-to-back CTBs
    for (int i = 0; i < 9; i++) run_comp(vecs[i], 1'b0, 1'b0);

    // Index jump 10 -> 12 drops to IDLE; following samples of that CTB are ignored
    for (int c = 0; c <= 10; c++) send(2'd0, c, 2'd2, 5'd1, 16'h1111, 0);
    send(2'd0, 12, 2'd2, 5'd1, 16'h1111, 0);
    chk("jump_perr", 32'(proto_err), 32'd1);
    feed_ignored(13, 39, "jump_no_result");
    run_comp(vecs[3], 1'b1, 1'b0);

    pulse_srst();
    chk("srst_perr", 32'(proto_err), 32'd0);
    chk("srst_type", 32'(sao_type), 32'd0);

    // Illegal type 3 mid-component
    for (int c = 0; c <= 4; c++) send(2'd0, c, 2'd2, 5'd1, 16'h1111, 0);
    send(2'd0, 5, 2'd3, 5'd1, 16'h1111, -20);
    chk("type3_perr", 32'(proto_err), 32'd1);
    feed_ignored(6, 39, "type3_no_result");

    // Wrong component after Y completes
    pulse_srst();
    run_comp(vecs[6], 1'b0, 1'b0);
    send(2'd2, 0, 2'd2, 5'd1, 16'h1111, 0);
    chk("cidx_perr", 32'(proto_err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
